// File: rtl/perf_mon_ctrl.sv
// perf_mon_ctrl: sampling-window controller for branch-predictor event counters with MMIO registers.
// Optional LFSR register at word 7 is built only when PERF_LFSR_EN is defined.
module perf_mon_ctrl #(
    parameter int ADDR_W = 3,
    parameter int CNT_W = 16,
    parameter logic [CNT_W-1:0] WIN_RST = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_br_cnt,
    input  logic              inc_hit_cnt,
    input  logic              inc_mispr_cnt,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic              mm_we,
    input  logic              mm_re,
    input  logic [CNT_W-1:0]  mm_wdata,
    output logic [CNT_W-1:0]  mm_rdata,
    output logic              win_irq,
    output logic              run
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;

    state_t state_q, state_d;
    logic [CNT_W-1:0] br_q, hit_q, mis_q, timer_q, window_q;
    logic [CNT_W-1:0] snap_br_q, snap_hit_q, snap_mis_q, snap_cyc_q, rdata_q;
    logic [CNT_W-1:0] br_nx, hit_nx, mis_nx, rd_mux, lfsr_val;
    logic [3:0] status_q, status_d;
    logic cont_q, irq_q, run_q;
    logic ctrl_we, start, stop, clr, cnt_en, win_end, end_evt, snap_evt, restart;

    assign ctrl_we  = mm_we && mm_addr == ADDR_W'(0);
    assign start    = ctrl_we && mm_wdata[0];
    assign stop     = ctrl_we && mm_wdata[1];
    assign clr      = ctrl_we && mm_wdata[2];
    // Strobes count in RUN unless a clear or a plain restart discards this cycle.
    assign cnt_en   = state_q == RUN && !clr && (stop || !start);
    assign win_end  = timer_q == window_q - 1'b1;
    assign end_evt  = cnt_en && !stop && win_end;
    assign snap_evt = cnt_en && (stop || win_end);
    assign restart  = clr || (start && !stop);

    assign br_nx  = br_q + CNT_W'(inc_br_cnt && br_q != MAX);
    assign hit_nx = hit_q + CNT_W'(inc_hit_cnt && hit_q != MAX);
    assign mis_nx = mis_q + CNT_W'(inc_mispr_cnt && mis_q != MAX);

    assign status_d = clr ? 4'b0 :
        (status_q & ~((mm_we && mm_addr == ADDR_W'(6)) ? mm_wdata[3:0] : 4'b0)) |
        {cnt_en && inc_mispr_cnt && mis_q == MAX, cnt_en && inc_hit_cnt && hit_q == MAX,
         cnt_en && inc_br_cnt && br_q == MAX, end_evt};

    assign state_d = clr ? ((start && !stop) ? RUN : state_q) :
                     stop ? IDLE :
                     start ? RUN :
                     (end_evt && !cont_q) ? DONE : state_q;

    always_comb begin
        rd_mux = '0;
        case (mm_addr)
            ADDR_W'(0): rd_mux = {{(CNT_W-4){1'b0}}, cont_q, state_q, 1'b0};
            ADDR_W'(1): rd_mux = window_q;
            ADDR_W'(2): rd_mux = snap_br_q;
            ADDR_W'(3): rd_mux = snap_hit_q;
            ADDR_W'(4): rd_mux = snap_mis_q;
            ADDR_W'(5): rd_mux = snap_cyc_q;
            ADDR_W'(6): rd_mux = {{(CNT_W-4){1'b0}}, status_q};
            default:    rd_mux = lfsr_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            irq_q      <= 1'b0;
            status_q   <= '0;
            cont_q     <= 1'b0;
            window_q   <= WIN_RST;
            rdata_q    <= '0;
            br_q       <= '0;
            hit_q      <= '0;
            mis_q      <= '0;
            timer_q    <= '0;
            snap_br_q  <= '0;
            snap_hit_q <= '0;
            snap_mis_q <= '0;
            snap_cyc_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= state_d == RUN;
            irq_q    <= end_evt;
            status_q <= status_d;
            if (ctrl_we) cont_q <= mm_wdata[3];
            if (mm_we && mm_addr == ADDR_W'(1)) window_q <= mm_wdata;
            if (mm_re) rdata_q <= rd_mux;
            if (restart || (end_evt && cont_q)) begin
                br_q    <= '0;
                hit_q   <= '0;
                mis_q   <= '0;
                timer_q <= '0;
            end else if (cnt_en) begin
                br_q    <= br_nx;
                hit_q   <= hit_nx;
                mis_q   <= mis_nx;
                timer_q <= timer_q + 1'b1;
            end
            if (clr) begin
                snap_br_q  <= '0;
                snap_hit_q <= '0;
                snap_mis_q <= '0;
                snap_cyc_q <= '0;
            end else if (snap_evt) begin
                snap_br_q  <= br_nx;
                snap_hit_q <= hit_nx;
                snap_mis_q <= mis_nx;
                snap_cyc_q <= timer_q + 1'b1;
            end
        end
    end

`ifdef PERF_LFSR_EN
    logic [15:0] lfsr_q;
    // Fibonacci taps 16,14,13,11 in shift-right form.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else if (mm_we && mm_addr == ADDR_W'(7)) lfsr_q <= (mm_wdata[15:0] == 16'h0) ? 16'hACE1 : mm_wdata[15:0];
        else lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign lfsr_val = CNT_W'(lfsr_q);
`else
    assign lfsr_val = '0;
`endif

    assign mm_rdata = rdata_q;
    assign win_irq  = irq_q;
    assign run      = run_q;
endmodule

// File: tb/tb_perf_mon_ctrl.sv
// tb_perf_mon_ctrl: scoreboard bench for perf_mon_ctrl; reads and irq times are queued and checked by a monitor.
module tb_perf_mon_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, mm_we, mm_re, win_irq, run;
    logic [2:0] mm_addr;
    logic [15:0] mm_wdata, mm_rdata;

    perf_mon_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt),
        .inc_mispr_cnt(inc_mispr_cnt), .mm_addr(mm_addr), .mm_we(mm_we), .mm_re(mm_re),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .win_irq(win_irq), .run(run)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    logic [15:0] exp_q[$];
    string name_q[$];
    longint irq_q[$];
    logic re_p = 1'b0;

    function automatic void chk(input string n, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    endfunction

    always @(posedge clk) re_p <= mm_re;

    always @(negedge clk) begin
        if (re_p) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL rd_unexpected: got 0x%0h with no expected read", mm_rdata);
            end else chk(name_q.pop_front(), longint'(mm_rdata), longint'(exp_q.pop_front()));
        end
        if (win_irq) begin
            if (irq_q.size() == 0) begin
                checks++;
                $display("FAIL irq_unexpected: pulse at %0t, none expected", $time);
            end else chk("win_irq_time", longint'($time), irq_q.pop_front());
        end
    end

    task automatic cyc(input logic we, input logic re, input logic [2:0] a, input logic [15:0] d,
                       input logic b, input logic h, input logic m);
        mm_we = we; mm_re = re; mm_addr = a; mm_wdata = d;
        inc_br_cnt = b; inc_hit_cnt = h; inc_mispr_cnt = m;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        cyc(1'b0, 1'b1, a, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: time %0t exceeded limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        int w, k, cb, ch, cm;
        logic b, h, m;
        logic [15:0] seed;
        mm_we = 0; mm_re = 0; mm_addr = 0; mm_wdata = 0;
        inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_win_irq", longint'(win_irq), 0);
        chk("rst_run", longint'(run), 0);
        rd(3'd0, 16'h0, "rst_ctrl");
        rd(3'd1, 16'hFFFF, "rst_window");
        for (int a = 2; a < 7; a++) rd(3'(a), 16'h0, "rst_snap_status");

        // single window of 10 cycles
        wr(3'd1, 16'd10);
        wr(3'd0, 16'h1);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) irq_q.push_back(longint'($time) + 10);
            cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, i % 3 == 0, 1'b0);
        end
        chk("done_run", longint'(run), 0);
        rd(3'd2, 16'd10, "w10_snap_br");
        rd(3'd3, 16'd4, "w10_snap_hit");
        rd(3'd4, 16'd0, "w10_snap_mispr");
        rd(3'd5, 16'd10, "w10_snap_cyc");
        rd(3'd6, 16'h1, "w10_status");
        rd(3'd0, 16'h4, "w10_ctrl_done");

        // continuous windows of 5
        wr(3'd6, 16'hF);
        wr(3'd1, 16'd5);
        wr(3'd0, 16'h9);
        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 4) irq_q.push_back(longint'($time) + 10);
            if (i == 6 || i == 11) begin
                exp_q.push_back(16'd5);
                name_q.push_back("cont_snap_mispr");
            end
            cyc(1'b0, i == 6 || i == 11, 3'd4, 16'h0, 1'b0, 1'b0, 1'b1);
            chk("cont_run", longint'(run), 1);
        end
        wr(3'd0, 16'h2);
        chk("cont_stop_run", longint'(run), 0);
        rd(3'd0, 16'h0, "cont_ctrl_idle");
        rd(3'd4, 16'h0, "cont_stop_snap_mispr");
        rd(3'd5, 16'd1, "cont_stop_snap_cyc");
        rd(3'd6, 16'h1, "cont_status");

        // WINDOW=0: 65536-cycle window with saturation
        wr(3'd6, 16'hF);
        wr(3'd1, 16'h0);
        wr(3'd0, 16'h1);
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) irq_q.push_back(longint'($time) + 10);
            cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        end
        rd(3'd6, 16'h3, "sat_status");
        rd(3'd2, 16'hFFFF, "sat_snap_br");
        rd(3'd3, 16'h0, "sat_snap_hit");
        rd(3'd5, 16'h0, "sat_snap_cyc");
        rd(3'd0, 16'h4, "sat_ctrl");
        wr(3'd6, 16'h3);
        rd(3'd6, 16'h0, "w1c_status");

        // stop at cycle 37 of a 100-cycle window
        wr(3'd1, 16'd100);
        wr(3'd0, 16'h1);
        cb = 0; ch = 0; cm = 0;
        for (int i = 0; i < 37; i++) begin
            b = rb(); h = rb(); m = rb();
            cb += int'(b); ch += int'(h); cm += int'(m);
            cyc(i == 36, 1'b0, 3'd0, 16'h2, b, h, m);
        end
        rd(3'd2, 16'(cb), "stop_snap_br");
        rd(3'd3, 16'(ch), "stop_snap_hit");
        rd(3'd4, 16'(cm), "stop_snap_mispr");
        rd(3'd5, 16'd37, "stop_snap_cyc");
        rd(3'd6, 16'h0, "stop_status");
        rd(3'd0, 16'h0, "stop_ctrl");
        wr(3'd0, 16'h4);
        for (int a = 2; a < 6; a++) rd(3'(a), 16'h0, "clear_snap");
        rd(3'd0, 16'h0, "clear_ctrl_idle");

        // random windows, some with a mid-window restart
        for (int it = 0; it < 6; it++) begin
            w = int'($urandom_range(2, 40));
            k = int'($urandom_range(0, w - 2));
            wr(3'd1, 16'(w));
            cyc(1'b1, 1'b0, 3'd0, 16'h1, rb(), rb(), rb());
            if (k > 0) begin
                repeat (k) cyc(1'b0, 1'b0, 3'd0, 16'h0, rb(), rb(), rb());
                cyc(1'b1, 1'b0, 3'd0, 16'h1, rb(), rb(), rb());
            end
            cb = 0; ch = 0; cm = 0;
            for (int i = 0; i < w; i++) begin
                if (i == w - 1) irq_q.push_back(longint'($time) + 10);
                b = rb(); h = rb(); m = rb();
                cb += int'(b); ch += int'(h); cm += int'(m);
                cyc(1'b0, 1'b0, 3'd0, 16'h0, b, h, m);
            end
            rd(3'd2, 16'(cb), "rnd_snap_br");
            rd(3'd3, 16'(ch), "rnd_snap_hit");
            rd(3'd4, 16'(cm), "rnd_snap_mispr");
            rd(3'd5, 16'(w), "rnd_snap_cyc");
            rd(3'd6, 16'h1, "rnd_status");
            rd(3'd0, 16'h4, "rnd_ctrl");
            wr(3'd6, 16'h1);
        end

        // clear+start from DONE, then stop
        wr(3'd0, 16'h5);
        chk("clrstart_run", longint'(run), 1);
        rd(3'd2, 16'h0, "clrstart_snap_br");
        rd(3'd0, 16'h2, "clrstart_ctrl_run");
        wr(3'd0, 16'h2);

        // same-cycle write and read returns the old value
        exp_q.push_back(16'(w));
        name_q.push_back("we_re_old");
        cyc(1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 1'b0, 1'b0);
        rd(3'd1, 16'h1234, "we_re_new");

`ifdef PERF_LFSR_EN
        wr(3'd7, 16'h0);
        exp_q.push_back(16'hACE1); name_q.push_back("lfsr_seed");
        exp_q.push_back(16'h5670); name_q.push_back("lfsr_step");
        cyc(1'b0, 1'b1, 3'd7, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd7, 16'h0, 1'b0, 1'b0, 1'b0);
        seed = 16'($urandom_range(1, 65535));
        wr(3'd7, seed);
        rd(3'd7, seed, "lfsr_reseed");
        rd(3'd7, {seed[0] ^ seed[2] ^ seed[3] ^ seed[5], seed[15:1]}, "lfsr_reseed_step");
`else
        seed = 16'h1234;
        rd(3'd7, 16'h0, "reg7_zero");
        wr(3'd7, seed);
        rd(3'd7, 16'h0, "reg7_write_ignored");
`endif

        repeat (3) cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("rd_queue_empty", longint'(exp_q.size()), 0);
        chk("irq_queue_empty", longint'(irq_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
